// File: rtl/eeprom_pkg.sv
// eeprom_pkg: operation codes, arbiter states and device code shared with the EEPROM controller
package eeprom_pkg;
  localparam logic [1:0] P_W = 2'd1;
  localparam logic [1:0] P_R = 2'd2;
  localparam logic [3:0] DEV_CODE = 4'b1010;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WSTREAM, S_WAIT_DONE, S_RELEASE} state_t;
  function automatic logic op_ok(input logic [1:0] t, input logic [7:0] n);
    return (t == P_W || t == P_R) && n != 8'd0;
  endfunction
endpackage

// File: rtl/eeprom_user_arbiter_if.sv
// eeprom_user_arbiter_if: operation, write-stream and read-stream bus between arbiter and controller
interface eeprom_user_arbiter_if;
  logic [2:0] eeprom_addr;
  logic [15:0] op_addr;
  logic [1:0] op_type;
  logic [7:0] op_len;
  logic op_valid;
  logic ctrl_ready;
  logic [7:0] wdata;
  logic wvalid;
  logic wsop;
  logic weop;
  logic [7:0] rdata;
  logic rvalid;
  modport master (
    output eeprom_addr, op_addr, op_type, op_len, op_valid, wdata, wvalid, wsop, weop,
    input ctrl_ready, rdata, rvalid
  );
  modport slave (
    input eeprom_addr, op_addr, op_type, op_len, op_valid, wdata, wvalid, wsop, weop,
    output ctrl_ready, rdata, rvalid
  );
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin selector remembering the last served requester
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic       i_update,
  input  logic       i_served_id,
  output logic       o_sel
);
  logic last_q;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) last_q <= 1'b1;
    else if (i_update) last_q <= i_served_id;
  assign o_sel = &i_req ? ~last_q : i_req[1];
endmodule

// File: rtl/eeprom_user_arbiter.sv
// eeprom_user_arbiter: round-robin owner of the EEPROM controller for whole transactions of two requesters
module eeprom_user_arbiter
  import eeprom_pkg::*;
#(
  parameter logic [23:0] P_TIMEOUT_CYC = 24'd2_000_000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [2:0]  i_req0_eeprom_addr,
  input  logic [15:0] i_req0_addr,
  input  logic [1:0]  i_req0_type,
  input  logic [7:0]  i_req0_len,
  input  logic        i_req0_valid,
  output logic        o_req0_ready,
  input  logic [7:0]  i_req0_wdata,
  input  logic        i_req0_wvalid,
  input  logic        i_req0_wsop,
  input  logic        i_req0_weop,
  output logic [7:0]  o_req0_rdata,
  output logic        o_req0_rvalid,
  output logic        o_req0_err,
  input  logic [2:0]  i_req1_eeprom_addr,
  input  logic [15:0] i_req1_addr,
  input  logic [1:0]  i_req1_type,
  input  logic [7:0]  i_req1_len,
  input  logic        i_req1_valid,
  output logic        o_req1_ready,
  input  logic [7:0]  i_req1_wdata,
  input  logic        i_req1_wvalid,
  input  logic        i_req1_wsop,
  input  logic        i_req1_weop,
  output logic [7:0]  o_req1_rdata,
  output logic        o_req1_rvalid,
  output logic        o_req1_err,
  eeprom_user_arbiter_if.master bus,
  output logic [1:0]  o_grant,
  output logic        o_timeout
);
  state_t state_q, state_d;
  logic owner_q, owner_d;
  logic [1:0] grant_q, grant_d;
  logic [2:0] eaddr_q, eaddr_d;
  logic [15:0] addr_q, addr_d;
  logic [1:0] type_q, type_d;
  logic [7:0] len_q, len_d;
  logic [7:0] rcnt_q, rcnt_d;
  logic op_valid_q, op_valid_d;
  logic rdy_q;
  logic [1:0] err_q, err_d;
  logic [1:0] rvalid_q, rvalid_d;
  logic [7:0] rdata_q;
  logic [23:0] wd_q, wd_d;
  logic sel, hs, upd, upd_id, rbeat, idle;
  logic [2:0] s_eaddr;
  logic [15:0] s_addr;
  logic [1:0] s_type;
  logic [7:0] s_len;
  rr_arb2 u_arb (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_req       ({i_req1_valid, i_req0_valid}),
    .i_update    (upd),
    .i_served_id (upd_id),
    .o_sel       (sel)
  );
  assign idle = state_q == S_IDLE;
  assign o_req0_ready = i_rst_n & idle & bus.ctrl_ready & ~sel;
  assign o_req1_ready = i_rst_n & idle & bus.ctrl_ready & sel;
  assign hs = sel ? i_req1_valid & o_req1_ready : i_req0_valid & o_req0_ready;
  assign s_eaddr = sel ? i_req1_eeprom_addr : i_req0_eeprom_addr;
  assign s_addr = sel ? i_req1_addr : i_req0_addr;
  assign s_type = sel ? i_req1_type : i_req0_type;
  assign s_len = sel ? i_req1_len : i_req0_len;
  assign o_timeout = !idle && state_q != S_RELEASE && wd_q == P_TIMEOUT_CYC - 24'd1;
  assign bus.wvalid = state_q == S_WSTREAM && (owner_q ? i_req1_wvalid : i_req0_wvalid);
  assign bus.wsop = state_q == S_WSTREAM && (owner_q ? i_req1_wsop : i_req0_wsop);
  assign bus.weop = state_q == S_WSTREAM && (owner_q ? i_req1_weop : i_req0_weop);
  assign bus.wdata = state_q == S_WSTREAM ? (owner_q ? i_req1_wdata : i_req0_wdata) : 8'd0;
  assign rbeat = state_q == S_WAIT_DONE && type_q == P_R && bus.rvalid && rcnt_q != len_q;
  assign bus.eeprom_addr = eaddr_q;
  assign bus.op_addr = addr_q;
  assign bus.op_type = type_q;
  assign bus.op_len = len_q;
  assign bus.op_valid = op_valid_q;
  assign o_grant = grant_q;
  assign o_req0_err = err_q[0];
  assign o_req1_err = err_q[1];
  assign o_req0_rvalid = rvalid_q[0];
  assign o_req1_rvalid = rvalid_q[1];
  assign o_req0_rdata = rvalid_q[0] ? rdata_q : 8'd0;
  assign o_req1_rdata = rvalid_q[1] ? rdata_q : 8'd0;
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    grant_d = grant_q;
    eaddr_d = eaddr_q;
    addr_d = addr_q;
    type_d = type_q;
    len_d = len_q;
    op_valid_d = op_valid_q;
    err_d = 2'b00;
    rvalid_d = rbeat ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    rcnt_d = rcnt_q + {7'd0, rbeat};
    wd_d = idle ? 24'd0 : wd_q + 24'd1;
    upd = 1'b0;
    upd_id = owner_q;
    case (state_q)
      S_IDLE: begin
        rcnt_d = 8'd0;
        if (hs) begin
          owner_d = sel;
          eaddr_d = s_eaddr;
          addr_d = s_addr;
          type_d = s_type;
          len_d = s_len;
          if (op_ok(s_type, s_len)) begin
            state_d = S_ISSUE;
            grant_d = sel ? 2'b10 : 2'b01;
            op_valid_d = 1'b1;
          end else begin
            err_d = sel ? 2'b10 : 2'b01;
            upd = 1'b1;
            upd_id = sel;
          end
        end
      end
      S_ISSUE:
        if (op_valid_q && bus.ctrl_ready) begin
          op_valid_d = 1'b0;
          state_d = type_q == P_W ? S_WSTREAM : S_WAIT_DONE;
        end
      S_WSTREAM: state_d = bus.wvalid && bus.weop ? S_WAIT_DONE : S_WSTREAM;
      S_WAIT_DONE:
        if (type_q == P_W ? (bus.ctrl_ready && !rdy_q) : (rcnt_q == len_q && bus.ctrl_ready))
          state_d = S_RELEASE;
      default: begin
        state_d = S_IDLE;
        upd = 1'b1;
      end
    endcase
    if (o_timeout) begin
      state_d = S_RELEASE;
      op_valid_d = 1'b0;
    end
    if (state_d == S_RELEASE) grant_d = 2'b00;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      grant_q <= 2'b00;
      eaddr_q <= 3'd0;
      addr_q <= 16'd0;
      type_q <= 2'd0;
      len_q <= 8'd0;
      rcnt_q <= 8'd0;
      op_valid_q <= 1'b0;
      rdy_q <= 1'b0;
      err_q <= 2'b00;
      rvalid_q <= 2'b00;
      rdata_q <= 8'd0;
      wd_q <= 24'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      eaddr_q <= eaddr_d;
      addr_q <= addr_d;
      type_q <= type_d;
      len_q <= len_d;
      rcnt_q <= rcnt_d;
      op_valid_q <= op_valid_d;
      rdy_q <= bus.ctrl_ready;
      err_q <= err_d;
      rvalid_q <= rvalid_d;
      rdata_q <= rbeat ? bus.rdata : rdata_q;
      wd_q <= wd_d;
    end
endmodule

// File: tb/tb_eeprom_user_arbiter.sv
// tb_eeprom_user_arbiter: directed self-checking bench for the two-port EEPROM arbiter
module tb_eeprom_user_arbiter;
  import eeprom_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] i_req0_eeprom_addr = '0, i_req1_eeprom_addr = '0;
  logic [15:0] i_req0_addr = '0, i_req1_addr = '0;
  logic [1:0] i_req0_type = '0, i_req1_type = '0;
  logic [7:0] i_req0_len = '0, i_req1_len = '0;
  logic i_req0_valid = 1'b0, i_req1_valid = 1'b0;
  logic [7:0] i_req0_wdata = '0, i_req1_wdata = '0;
  logic i_req0_wvalid = 1'b0, i_req1_wvalid = 1'b0;
  logic i_req0_wsop = 1'b0, i_req1_wsop = 1'b0;
  logic i_req0_weop = 1'b0, i_req1_weop = 1'b0;
  logic o_req0_ready, o_req1_ready, o_req0_rvalid, o_req1_rvalid, o_req0_err, o_req1_err, o_timeout;
  logic [7:0] o_req0_rdata, o_req1_rdata;
  logic [1:0] o_grant;
  int n_run = 0;
  int n_fail = 0;
  int k;
  eeprom_user_arbiter_if bus ();
  eeprom_user_arbiter #(.P_TIMEOUT_CYC(24'd100)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0_eeprom_addr(i_req0_eeprom_addr), .i_req0_addr(i_req0_addr), .i_req0_type(i_req0_type),
    .i_req0_len(i_req0_len), .i_req0_valid(i_req0_valid), .o_req0_ready(o_req0_ready),
    .i_req0_wdata(i_req0_wdata), .i_req0_wvalid(i_req0_wvalid), .i_req0_wsop(i_req0_wsop),
    .i_req0_weop(i_req0_weop), .o_req0_rdata(o_req0_rdata), .o_req0_rvalid(o_req0_rvalid),
    .o_req0_err(o_req0_err),
    .i_req1_eeprom_addr(i_req1_eeprom_addr), .i_req1_addr(i_req1_addr), .i_req1_type(i_req1_type),
    .i_req1_len(i_req1_len), .i_req1_valid(i_req1_valid), .o_req1_ready(o_req1_ready),
    .i_req1_wdata(i_req1_wdata), .i_req1_wvalid(i_req1_wvalid), .i_req1_wsop(i_req1_wsop),
    .i_req1_weop(i_req1_weop), .o_req1_rdata(o_req1_rdata), .o_req1_rvalid(o_req1_rvalid),
    .o_req1_err(o_req1_err),
    .bus(bus), .o_grant(o_grant), .o_timeout(o_timeout)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wr1(input logic [1:0] g, input string tag);
    #1 chk({tag, "_rdy"}, {o_req1_ready, o_req0_ready}, g);
    @(negedge clk);
    chk({tag, "_grant"}, o_grant, g);
    @(negedge clk);
    i_req0_wvalid = g[0];
    i_req1_wvalid = g[1];
    i_req0_weop = 1'b1;
    i_req1_weop = 1'b1;
    #1 chk({tag, "_wv"}, bus.wvalid, 1);
    @(negedge clk);
    i_req0_wvalid = 1'b0;
    i_req1_wvalid = 1'b0;
    bus.ctrl_ready = 1'b0;
    @(negedge clk);
    bus.ctrl_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_rel"}, o_grant, 0);
    @(negedge clk);
  endtask
  initial begin
    bus.ctrl_ready = 1'b1;
    bus.rdata = 8'd0;
    bus.rvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_grant", o_grant, 0);
    chk("rst_rdy", {o_req1_ready, o_req0_ready}, 0);
    chk("rst_opv", bus.op_valid, 0);
    chk("rst_to", o_timeout, 0);
    rst_n = 1'b1;
    @(negedge clk);
    // port 0 writes four bytes while port 1 drives a stray write stream
    i_req0_valid = 1; i_req0_type = P_W; i_req0_len = 8'd4; i_req0_addr = 16'h0010; i_req0_eeprom_addr = 3'd1;
    i_req1_wvalid = 1; i_req1_wdata = 8'hEE; i_req1_weop = 1; i_req1_wsop = 1;
    #1 chk("t1_rdy0", o_req0_ready, 1);
    @(negedge clk);
    i_req0_valid = 0;
    bus.ctrl_ready = 0;
    chk("t1_opv", bus.op_valid, 1);
    chk("t1_addr", bus.op_addr, 16'h0010);
    chk("t1_type", bus.op_type, 1);
    chk("t1_len", bus.op_len, 4);
    chk("t1_ea", bus.eeprom_addr, 1);
    chk("t1_grant", o_grant, 2'b01);
    chk("t1_wv_issue", bus.wvalid, 0);
    @(negedge clk);
    chk("t1_opv_hold", bus.op_valid, 1);
    bus.ctrl_ready = 1;
    @(negedge clk);
    chk("t1_opv_drop", bus.op_valid, 0);
    bus.ctrl_ready = 0;
    for (int i = 0; i < 4; i++) begin
      i_req0_wvalid = 1; i_req0_wdata = 8'hA1 + 8'(i); i_req0_wsop = (i == 0); i_req0_weop = (i == 3);
      #1 chk("t1_wv", bus.wvalid, 1);
      chk("t1_wd", bus.wdata, 8'hA1 + i);
      chk("t1_weop", bus.weop, i == 3);
      @(negedge clk);
    end
    i_req0_wvalid = 0;
    chk("t1_wv_done", bus.wvalid, 0);
    chk("t1_grant_wait", o_grant, 2'b01);
    @(negedge clk);
    chk("t1_grant_wait2", o_grant, 2'b01);
    bus.ctrl_ready = 1;
    @(negedge clk);
    chk("t1_release", o_grant, 0);
    @(negedge clk);
    i_req1_wvalid = 0; i_req1_weop = 0; i_req1_wsop = 0;
    // port 1 reads three bytes; a fourth controller beat must be dropped
    i_req1_valid = 1; i_req1_type = P_R; i_req1_len = 8'd3; i_req1_addr = 16'h0100; i_req1_eeprom_addr = 3'd2;
    #1 chk("t2_rdy", {o_req1_ready, o_req0_ready}, 2'b10);
    @(negedge clk);
    i_req1_valid = 0;
    chk("t2_grant", o_grant, 2'b10);
    chk("t2_addr", bus.op_addr, 16'h0100);
    chk("t2_type", bus.op_type, 2);
    chk("t2_len", bus.op_len, 3);
    @(negedge clk);
    chk("t2_opv_drop", bus.op_valid, 0);
    bus.ctrl_ready = 0;
    for (int i = 0; i < 4; i++) begin
      bus.rvalid = 1; bus.rdata = 8'h11 * 8'(i + 1);
      @(negedge clk);
      chk("t2_rv1", o_req1_rvalid, i < 3);
      chk("t2_rv0", o_req0_rvalid, 0);
      if (i < 3) chk("t2_rd", o_req1_rdata, 8'h11 * (i + 1));
    end
    bus.rvalid = 0;
    chk("t2_grant_wait", o_grant, 2'b10);
    bus.ctrl_ready = 1;
    @(negedge clk);
    chk("t2_release", o_grant, 0);
    @(negedge clk);
    // malformed requests from port 0: bad type, then zero length
    i_req0_valid = 1; i_req0_type = 2'd3; i_req0_len = 8'd4;
    #1 chk("t4a_rdy", o_req0_ready, 1);
    @(negedge clk);
    i_req0_valid = 0;
    chk("t4a_err", {o_req1_err, o_req0_err}, 2'b01);
    chk("t4a_opv", bus.op_valid, 0);
    chk("t4a_grant", o_grant, 0);
    @(negedge clk);
    chk("t4a_err_end", o_req0_err, 0);
    chk("t4a_opv2", bus.op_valid, 0);
    i_req0_valid = 1; i_req0_type = P_W; i_req0_len = 8'd0;
    #1 chk("t4b_rdy", o_req0_ready, 1);
    @(negedge clk);
    i_req0_valid = 0;
    chk("t4b_err", o_req0_err, 1);
    chk("t4b_opv", bus.op_valid, 0);
    @(negedge clk);
    chk("t4b_err_end", o_req0_err, 0);
    chk("t4b_opv2", bus.op_valid, 0);
    // read accepted, then controller stalls until the watchdog fires
    i_req0_valid = 1; i_req0_type = P_R; i_req0_len = 8'd2;
    @(negedge clk);
    i_req0_valid = 0;
    k = 0;
    @(negedge clk);
    bus.ctrl_ready = 0;
    k = 1;
    chk("t5_acc", bus.op_valid, 0);
    while (!o_timeout && k < 150) begin
      @(negedge clk);
      k++;
    end
    chk("t5_cycle", k, 99);
    chk("t5_grant_at", o_grant, 2'b01);
    @(negedge clk);
    chk("t5_pulse", o_timeout, 0);
    chk("t5_rel", o_grant, 0);
    @(negedge clk);
    bus.ctrl_ready = 1;
    // next request is accepted, then reset lands in the middle of its write stream
    i_req0_valid = 1; i_req0_type = P_W; i_req0_len = 8'd2;
    #1 chk("t5_next_rdy", o_req0_ready, 1);
    @(negedge clk);
    i_req0_valid = 0;
    chk("t5_next_grant", o_grant, 2'b01);
    @(negedge clk);
    i_req0_wvalid = 1; i_req0_wdata = 8'h5A; i_req0_wsop = 1; i_req0_weop = 0;
    #1 chk("t6_wv", bus.wvalid, 1);
    #2 rst_n = 0;
    #1 chk("t6_grant", o_grant, 0);
    chk("t6_wv0", bus.wvalid, 0);
    chk("t6_opv", bus.op_valid, 0);
    chk("t6_rdy", {o_req1_ready, o_req0_ready}, 0);
    chk("t6_err", {o_req1_err, o_req0_err}, 0);
    @(negedge clk);
    rst_n = 1;
    i_req0_wvalid = 0; i_req0_wsop = 0;
    // both ports hold valid: grants alternate 0, 1, 0
    i_req0_type = P_W; i_req0_len = 8'd1; i_req1_type = P_W; i_req1_len = 8'd1;
    i_req0_valid = 1; i_req1_valid = 1;
    wr1(2'b01, "t3a");
    wr1(2'b10, "t3b");
    wr1(2'b01, "t3c");
    i_req0_valid = 0; i_req1_valid = 0;
    @(negedge clk);
    chk("t3_idle", o_grant, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
